// File: rtl/rob_pkg.sv
// Shared ROB/retire definitions: field widths, retire FSM encoding and the
// hardwired-zero register index.
package rob_pkg;

  localparam int unsigned TAG_W  = 5;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2
  } retire_state_e;

endpackage

// File: rtl/retire_unit.sv
// Commit stage behind the ROB: pops the head, writes the register file,
// recycles tags, handshakes stores and flushes on a taken branch.
module retire_unit
  import rob_pkg::*;
#(
  parameter int unsigned TAG_W        = rob_pkg::TAG_W,
  parameter int unsigned REG_W        = rob_pkg::REG_W,
  parameter int unsigned DATA_W       = rob_pkg::DATA_W,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Retire_valid,
  input  logic [TAG_W-1:0]  Retire_rd_tag,
  input  logic [REG_W-1:0]  Retire_rd_reg,
  input  logic [DATA_W-1:0] Retire_data,
  input  logic [DATA_W-1:0] Retire_pc,
  input  logic              Retire_branch,
  input  logic              Retire_branch_taken,
  input  logic              Retire_store_ready,
  output logic              Retire_ack,
  output logic              Rf_wr_en,
  output logic [REG_W-1:0]  Rf_wr_reg,
  output logic [DATA_W-1:0] Rf_wr_data,
  output logic              Tag_release_valid,
  output logic [TAG_W-1:0]  Tag_release_tag,
  output logic              Store_commit_req,
  output logic [TAG_W-1:0]  Store_commit_tag,
  input  logic              Store_commit_ack,
  output logic              Flush,
  output logic [DATA_W-1:0] Flush_pc,
  output logic [31:0]       Commit_count,
  output logic [31:0]       Mispredict_count
);

  localparam int unsigned CNT_W = 4;

  retire_state_e     state_q, state_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              rf_wr_en_d;
  logic [REG_W-1:0]  rf_wr_reg_d;
  logic [DATA_W-1:0] rf_wr_data_d;
  logic              tag_rel_valid_d;
  logic [TAG_W-1:0]  tag_rel_tag_d;
  logic              store_req_d;
  logic [TAG_W-1:0]  store_tag_d;
  logic              flush_d;
  logic [DATA_W-1:0] flush_pc_d;
  logic              commit_inc;
  logic              mispredict_inc;

  // The PC travels with the head entry but the redirect comes from Retire_data.
  logic pc_unused;
  assign pc_unused = ^Retire_pc;

  // State and output registers; reset abandons any store or flush in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      flush_cnt_q       <= '0;
      Rf_wr_en          <= 1'b0;
      Rf_wr_reg         <= '0;
      Rf_wr_data        <= '0;
      Tag_release_valid <= 1'b0;
      Tag_release_tag   <= '0;
      Store_commit_req  <= 1'b0;
      Store_commit_tag  <= '0;
      Flush             <= 1'b0;
      Flush_pc          <= '0;
      Commit_count      <= '0;
      Mispredict_count  <= '0;
    end else begin
      state_q           <= state_d;
      flush_cnt_q       <= flush_cnt_d;
      Rf_wr_en          <= rf_wr_en_d;
      Rf_wr_reg         <= rf_wr_reg_d;
      Rf_wr_data        <= rf_wr_data_d;
      Tag_release_valid <= tag_rel_valid_d;
      Tag_release_tag   <= tag_rel_tag_d;
      Store_commit_req  <= store_req_d;
      Store_commit_tag  <= store_tag_d;
      Flush             <= flush_d;
      Flush_pc          <= flush_pc_d;
      Commit_count      <= Commit_count + 32'(commit_inc);
      Mispredict_count  <= Mispredict_count + 32'(mispredict_inc);
    end
  end

  // Next state, head pop and next values of the registered outputs.
  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    Retire_ack      = 1'b0;
    rf_wr_en_d      = 1'b0;
    rf_wr_reg_d     = Rf_wr_reg;
    rf_wr_data_d    = Rf_wr_data;
    tag_rel_valid_d = 1'b0;
    tag_rel_tag_d   = Tag_release_tag;
    store_req_d     = Store_commit_req;
    store_tag_d     = Store_commit_tag;
    flush_d         = Flush;
    flush_pc_d      = Flush_pc;
    commit_inc      = 1'b0;
    mispredict_inc  = 1'b0;

    case (state_q)
      IDLE: begin
        if (Retire_valid) begin
          if (Retire_store_ready) begin
            // Stores wait for the store buffer before the head is popped.
            store_req_d = 1'b1;
            store_tag_d = Retire_rd_tag;
            state_d     = STORE_WAIT;
          end else begin
            Retire_ack      = 1'b1;
            tag_rel_valid_d = 1'b1;
            tag_rel_tag_d   = Retire_rd_tag;
            commit_inc      = 1'b1;
            if (!Retire_branch) begin
              rf_wr_en_d   = (Retire_rd_reg != REG_W'(REG_ZERO));
              rf_wr_reg_d  = Retire_rd_reg;
              rf_wr_data_d = Retire_data;
            end else if (Retire_branch_taken) begin
              // Predicted not-taken, so any taken branch is a mispredict.
              flush_d        = 1'b1;
              flush_pc_d     = Retire_data;
              flush_cnt_d    = CNT_W'(FLUSH_CYCLES - 1);
              mispredict_inc = 1'b1;
              state_d        = FLUSH;
            end
          end
        end
      end

      STORE_WAIT: begin
        if (Store_commit_ack) begin
          Retire_ack      = 1'b1;
          store_req_d     = 1'b0;
          tag_rel_valid_d = 1'b1;
          tag_rel_tag_d   = Store_commit_tag;
          commit_inc      = 1'b1;
          state_d         = IDLE;
        end
      end

      FLUSH: begin
        if (flush_cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit: ALU stream, store handshake, branches,
// mispredict flush and asynchronous reset behaviour.
module tb_retire_unit;

  logic        clock;
  logic        reset;
  logic        Retire_valid;
  logic [4:0]  Retire_rd_tag;
  logic [4:0]  Retire_rd_reg;
  logic [31:0] Retire_data;
  logic [31:0] Retire_pc;
  logic        Retire_branch;
  logic        Retire_branch_taken;
  logic        Retire_store_ready;
  logic        Retire_ack;
  logic        Rf_wr_en;
  logic [4:0]  Rf_wr_reg;
  logic [31:0] Rf_wr_data;
  logic        Tag_release_valid;
  logic [4:0]  Tag_release_tag;
  logic        Store_commit_req;
  logic [4:0]  Store_commit_tag;
  logic        Store_commit_ack;
  logic        Flush;
  logic [31:0] Flush_pc;
  logic [31:0] Commit_count;
  logic [31:0] Mispredict_count;

  int checks = 0;
  int errors = 0;

  retire_unit dut (
    .clock               (clock),
    .reset               (reset),
    .Retire_valid        (Retire_valid),
    .Retire_rd_tag       (Retire_rd_tag),
    .Retire_rd_reg       (Retire_rd_reg),
    .Retire_data         (Retire_data),
    .Retire_pc           (Retire_pc),
    .Retire_branch       (Retire_branch),
    .Retire_branch_taken (Retire_branch_taken),
    .Retire_store_ready  (Retire_store_ready),
    .Retire_ack          (Retire_ack),
    .Rf_wr_en            (Rf_wr_en),
    .Rf_wr_reg           (Rf_wr_reg),
    .Rf_wr_data          (Rf_wr_data),
    .Tag_release_valid   (Tag_release_valid),
    .Tag_release_tag     (Tag_release_tag),
    .Store_commit_req    (Store_commit_req),
    .Store_commit_tag    (Store_commit_tag),
    .Store_commit_ack    (Store_commit_ack),
    .Flush               (Flush),
    .Flush_pc            (Flush_pc),
    .Commit_count        (Commit_count),
    .Mispredict_count    (Mispredict_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic head(input logic v, input logic [4:0] tag, input logic [4:0] rg,
                      input logic [31:0] data, input logic br, input logic tk,
                      input logic st);
    Retire_valid        = v;
    Retire_rd_tag       = tag;
    Retire_rd_reg       = rg;
    Retire_data         = data;
    Retire_pc           = 32'h1000 + {27'd0, tag};
    Retire_branch       = br;
    Retire_branch_taken = tk;
    Retire_store_ready  = st;
  endtask

  initial begin
    reset            = 1'b1;
    Store_commit_ack = 1'b0;
    head(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #3;
    check("rst_ack",   {31'd0, Retire_ack}, 32'd0);
    check("rst_wr",    {31'd0, Rf_wr_en}, 32'd0);
    check("rst_rel",   {31'd0, Tag_release_valid}, 32'd0);
    check("rst_req",   {31'd0, Store_commit_req}, 32'd0);
    check("rst_flush", {31'd0, Flush}, 32'd0);
    check("rst_ccnt",  Commit_count, 32'd0);
    check("rst_mcnt",  Mispredict_count, 32'd0);
    step();
    step();
    reset = 1'b0;

    // ALU stream: r7, r0 (suppressed), r9
    head(1'b1, 5'd3, 5'd7, 32'h11, 1'b0, 1'b0, 1'b0);
    #1 check("alu0_ack", {31'd0, Retire_ack}, 32'd1);
    step();
    head(1'b1, 5'd4, 5'd0, 32'h22, 1'b0, 1'b0, 1'b0);
    #1 check("alu1_ack", {31'd0, Retire_ack}, 32'd1);
    check("alu0_wr",   {31'd0, Rf_wr_en}, 32'd1);
    check("alu0_reg",  {27'd0, Rf_wr_reg}, 32'd7);
    check("alu0_data", Rf_wr_data, 32'h11);
    check("alu0_rel",  {31'd0, Tag_release_valid}, 32'd1);
    check("alu0_tag",  {27'd0, Tag_release_tag}, 32'd3);
    step();
    head(1'b1, 5'd5, 5'd9, 32'h33, 1'b0, 1'b0, 1'b0);
    #1 check("alu2_ack", {31'd0, Retire_ack}, 32'd1);
    check("alu1_wr_r0", {31'd0, Rf_wr_en}, 32'd0);
    check("alu1_rel",   {31'd0, Tag_release_valid}, 32'd1);
    check("alu1_tag",   {27'd0, Tag_release_tag}, 32'd4);
    step();
    head(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1 check("alu2_wr", {31'd0, Rf_wr_en}, 32'd1);
    check("alu2_reg",  {27'd0, Rf_wr_reg}, 32'd9);
    check("alu2_data", Rf_wr_data, 32'h33);
    check("alu2_tag",  {27'd0, Tag_release_tag}, 32'd5);
    check("idle_ack",  {31'd0, Retire_ack}, 32'd0);
    step();
    check("alu_wr_end",  {31'd0, Rf_wr_en}, 32'd0);
    check("alu_rel_end", {31'd0, Tag_release_valid}, 32'd0);
    check("alu_ccnt",    Commit_count, 32'd3);

    // Not-taken branch
    head(1'b1, 5'd10, 5'd6, 32'h99, 1'b1, 1'b0, 1'b0);
    #1 check("bnt_ack", {31'd0, Retire_ack}, 32'd1);
    step();
    head(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1 check("bnt_rel", {31'd0, Tag_release_valid}, 32'd1);
    check("bnt_tag",   {27'd0, Tag_release_tag}, 32'd10);
    check("bnt_wr",    {31'd0, Rf_wr_en}, 32'd0);
    check("bnt_flush", {31'd0, Flush}, 32'd0);
    check("bnt_ccnt",  Commit_count, 32'd4);
    step();
    check("bnt_flush2", {31'd0, Flush}, 32'd0);

    // Mispredict: Retire_valid held through the flush
    head(1'b1, 5'd20, 5'd2, 32'h40, 1'b1, 1'b1, 1'b0);
    #1 check("mp_ack", {31'd0, Retire_ack}, 32'd1);
    step();
    check("mp_flush1", {31'd0, Flush}, 32'd1);
    check("mp_pc1",    Flush_pc, 32'h40);
    check("mp_noack1", {31'd0, Retire_ack}, 32'd0);
    check("mp_mcnt",   Mispredict_count, 32'd1);
    check("mp_rel",    {31'd0, Tag_release_valid}, 32'd1);
    check("mp_tag",    {27'd0, Tag_release_tag}, 32'd20);
    check("mp_wr",     {31'd0, Rf_wr_en}, 32'd0);
    check("mp_ccnt",   Commit_count, 32'd5);
    step();
    check("mp_flush2", {31'd0, Flush}, 32'd1);
    check("mp_pc2",    Flush_pc, 32'h40);
    check("mp_noack2", {31'd0, Retire_ack}, 32'd0);
    check("mp_rel2",   {31'd0, Tag_release_valid}, 32'd0);
    check("mp_mcnt2",  Mispredict_count, 32'd1);
    step();
    head(1'b1, 5'd21, 5'd0, 32'h77, 1'b0, 1'b0, 1'b0);
    #1 check("mp_flush_end", {31'd0, Flush}, 32'd0);
    check("mp_resume_ack", {31'd0, Retire_ack}, 32'd1);
    step();
    head(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1 check("mp_next_tag", {27'd0, Tag_release_tag}, 32'd21);
    check("mp_next_rel", {31'd0, Tag_release_valid}, 32'd1);
    check("mp_next_ccnt", Commit_count, 32'd6);
    check("mp_mcnt3",     Mispredict_count, 32'd1);
    step();

    // Store ack while idle is ignored
    Store_commit_ack = 1'b1;
    #1 check("idle_sack_ack", {31'd0, Retire_ack}, 32'd0);
    step();
    check("idle_sack_rel", {31'd0, Tag_release_valid}, 32'd0);
    check("idle_sack_ccnt", Commit_count, 32'd6);

    // Store tag 12, ack after 3 waiting cycles
    head(1'b1, 5'd12, 5'd3, 32'h55, 1'b0, 1'b0, 1'b1);
    #1 check("st_noack0", {31'd0, Retire_ack}, 32'd0);
    step();
    Store_commit_ack = 1'b0;
    #1 check("st_req1", {31'd0, Store_commit_req}, 32'd1);
    check("st_tag1",   {27'd0, Store_commit_tag}, 32'd12);
    check("st_noack1", {31'd0, Retire_ack}, 32'd0);
    step();
    check("st_req2",   {31'd0, Store_commit_req}, 32'd1);
    check("st_noack2", {31'd0, Retire_ack}, 32'd0);
    step();
    check("st_req3",   {31'd0, Store_commit_req}, 32'd1);
    Store_commit_ack = 1'b1;
    #1 check("st_ack", {31'd0, Retire_ack}, 32'd1);
    step();
    Store_commit_ack = 1'b0;
    head(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1 check("st_req_drop", {31'd0, Store_commit_req}, 32'd0);
    check("st_rel",  {31'd0, Tag_release_valid}, 32'd1);
    check("st_tag",  {27'd0, Tag_release_tag}, 32'd12);
    check("st_wr",   {31'd0, Rf_wr_en}, 32'd0);
    check("st_ccnt", Commit_count, 32'd7);
    step();
    check("st_rel_end", {31'd0, Tag_release_valid}, 32'd0);

    // Reset in the middle of STORE_WAIT
    head(1'b1, 5'd17, 5'd4, 32'h66, 1'b0, 1'b0, 1'b1);
    step();
    head(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1 check("rsw_req", {31'd0, Store_commit_req}, 32'd1);
    check("rsw_tag",   {27'd0, Store_commit_tag}, 32'd17);
    #2 reset = 1'b1;
    #1 check("rsw_req_clr", {31'd0, Store_commit_req}, 32'd0);
    check("rsw_tag_clr",  {27'd0, Store_commit_tag}, 32'd0);
    check("rsw_rel",      {31'd0, Tag_release_valid}, 32'd0);
    check("rsw_ccnt",     Commit_count, 32'd0);
    check("rsw_mcnt",     Mispredict_count, 32'd0);
    check("rsw_pc",       Flush_pc, 32'd0);
    step();
    reset = 1'b0;
    Store_commit_ack = 1'b1;
    #1 check("rsw_late_ack", {31'd0, Retire_ack}, 32'd0);
    step();
    Store_commit_ack = 1'b0;
    check("rsw_late_rel",  {31'd0, Tag_release_valid}, 32'd0);
    check("rsw_late_req",  {31'd0, Store_commit_req}, 32'd0);
    check("rsw_late_ccnt", Commit_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/retire_unit.md
# retire_unit

Commit stage directly downstream of `rob`. It consumes the ROB head through the `Retire_*` bus and pops the head with `Retire_ack`. For each committed instruction it writes the architectural register file, returns the ROB tag to the free-tag FIFO that drives `new_rd_tag`, and handshakes stores with the store buffer. The design uses static not-taken branch prediction, so a retired taken branch raises a pipeline flush with a redirect PC.

## Interface
- `TAG_W`, default 5: ROB tag width (32 entries).
- `REG_W`, default 5: architectural register index width.
- `DATA_W`, default 32: data and PC width.
- `FLUSH_CYCLES`, default 2: number of cycles `Flush` is held; legal range 1..15.
- `clock`, in, 1: the single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `Retire_valid`, `Retire_rd_tag`, `Retire_rd_reg`, `Retire_data`, `Retire_pc`, `Retire_branch`, `Retire_branch_taken`, `Retire_store_ready`, in: ROB head entry (widths 1, TAG_W, REG_W, DATA_W, DATA_W, 1, 1, 1). For a branch, `Retire_data` carries the target address.
- `Retire_ack`, out, 1: combinational; pops the ROB head this cycle.
- `Rf_wr_en` / `Rf_wr_reg` / `Rf_wr_data`, out, 1/REG_W/DATA_W: registered register-file write.
- `Tag_release_valid` / `Tag_release_tag`, out, 1/TAG_W: registered push to the free-tag FIFO.
- `Store_commit_req` / `Store_commit_tag`, out, 1/TAG_W: store-buffer commit request.
- `Store_commit_ack`, in, 1: store buffer accepted the store.
- `Flush` / `Flush_pc`, out, 1/DATA_W: mispredict recovery and redirect address.
- `Commit_count` / `Mispredict_count`, out, 32/32: statistics counters.

## Operation
- FSM states: IDLE, STORE_WAIT, FLUSH. `reset` forces IDLE.

**IDLE**
- On `Retire_valid` with `Retire_store_ready=0`, assert `Retire_ack`. Then classify the instruction:
  - **ALU**: not a branch and not a store. Write the register file. No write occurs when `Retire_rd_reg==0` (register 0 is hardwired to zero).
  - **Branch not taken**: no register write.
  - **Branch taken**: mispredict. Capture `Flush_pc<=Retire_data` and go to FLUSH.
- Every acknowledged instruction releases its tag and increments `Commit_count`.
- On `Retire_valid` with `Retire_store_ready=1`:
  - Do not assert `Retire_ack`.
  - Register `Store_commit_req=1` and `Store_commit_tag=Retire_rd_tag`, then go to STORE_WAIT.

**STORE_WAIT**
- Hold the request until `Store_commit_ack`.
- When `Store_commit_ack=1`, assert `Retire_ack` that same cycle.
- Next cycle: drop the request, release the tag, increment `Commit_count`, and return to IDLE.
- A store never writes the register file.

**FLUSH**
- `Flush=1` for exactly FLUSH_CYCLES cycles, counted by an internal 4-bit counter. `Flush_pc` is stable throughout.
- `Retire_ack=0` in this state; `Retire_valid` is ignored because the ROB is being cleared.
- `Mispredict_count` increments once on entry.
- Return to IDLE after the last flush cycle.

**Boundary conditions**
- `Store_commit_ack` is ignored outside STORE_WAIT.
- Both counters wrap modulo 2^32.
- `Retire_store_ready` has priority over `Retire_branch` if both are set.
- Reset asserted mid-STORE_WAIT or mid-FLUSH abandons the operation. All outputs clear asynchronously and nothing is released.

## Timing
- Reset values: all outputs 0, counters 0, state IDLE.
- `Retire_ack` is combinational from `Retire_valid`, `Retire_store_ready`, `Store_commit_ack` and the state. The ROB pops on the same edge.
- Register write and tag release have 1-cycle latency after the ack edge. Each is a single-cycle pulse per instruction.
- Throughput for non-store, non-mispredict instructions is one per cycle; back-to-back acks produce back-to-back write pulses.
- Store: request rises 1 cycle after the head is sampled. The minimum store cost is 2 cycles (ack in the first STORE_WAIT cycle).
- Mispredict: `Flush` rises 1 cycle after the ack. The next retire is accepted FLUSH_CYCLES+1 cycles after the ack at the earliest.

## Structure
- Shared package `rob_pkg` holds:
  - `TAG_W`, `REG_W`, `DATA_W`, which the ROB already uses;
  - the retire state enum (IDLE=2'd0, STORE_WAIT=2'd1, FLUSH=2'd2);
  - the constant `REG_ZERO=0`.
- No sub-module: a single FSM block plus output registers and counters, roughly 200 lines.

## Test plan
- **Reset:** assert `reset` mid-cycle → all outputs 0 immediately, with no clock edge required.
- **ALU stream:** `Retire_valid=1` for 3 cycles with tags 3,4,5 and regs 7,0,9 → 3 consecutive acks. Writes go to r7 and r9 only, r0 is suppressed. Tags 3,4,5 are released in order. `Commit_count=3`.
- **Store:** head tag 12 with `Retire_store_ready=1`; `Store_commit_ack` given 3 cycles later → `Store_commit_req` high with tag 12 until the ack. `Retire_ack` coincides with the ack. Tag 12 is released the next cycle and there is no `Rf_wr_en`.
- **Mispredict:** branch tag 20, taken, `Retire_data=0x40` → `Flush=1` for 2 cycles with `Flush_pc=0x40`. `Mispredict_count=1`. `Retire_valid` is held high during the flush and gets no ack.
- **Not-taken branch:** tag 10 → ack, tag 10 released, no flush, no write.
- **Reset in STORE_WAIT:** assert `reset` while waiting for the store ack → request drops, no tag release, FSM in IDLE; a later ack is ignored.
